fds_channel_scheduler: RTL and testbench

//  Sequences the flexible-downsampling datapath one channel at a time.
//  - Streams each HIN x HIN input channel slice row by row from ifmap SRAM into the slice register.
//  - Waits for the combinational/pipelined downsample core to settle.
//  - Hands the HOUT output rows of that channel to the ofmap writer over a valid/ready handshake.
//  - Control-only block: it issues addresses, strobes and row/channel tags, never data.

---
 rtl/fds_channel_scheduler.sv | 173 +++++++++++++++++
 tb/tb_fds_channel_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fds_channel_scheduler.sv
// Channel sequencer for the flexible-downsampling datapath: streams one channel slice from
// ifmap SRAM, waits for the downsample core, then hands its output rows to the ofmap writer.
module fds_channel_scheduler #(
   parameter int CIN    = 64,
   parameter int HIN    = 27,
   parameter int HOUT   = 19,
   parameter int RD_LAT = 1,
   parameter int DS_LAT = 2,
   localparam int AW    = (CIN * HIN > 1) ? $clog2(CIN * HIN) : 1,
   localparam int RW    = (HIN > 1) ? $clog2(HIN) : 1,
   localparam int OW    = (HOUT > 1) ? $clog2(HOUT) : 1,
   localparam int CW    = (CIN > 1) ? $clog2(CIN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   output logic          slice_we,
   output logic [RW-1:0] slice_row,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_row,
   output logic [CW-1:0] out_ch
);

   // WAIT spans the SRAM return of the last row plus the core settling time.
   localparam int WAIT_CYC = RD_LAT + DS_LAT;
   localparam int WW       = $clog2(WAIT_CYC + 1);

   localparam logic [RW-1:0] ROW_LAST  = RW'(HIN - 1);
   localparam logic [OW-1:0] OROW_LAST = OW'(HOUT - 1);
   localparam logic [CW-1:0] CH_LAST   = CW'(CIN - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [OW-1:0] orow_q, orow_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          flush;

   logic [RD_LAT-1:0] we_pipe;
   logic [RW-1:0]     row_pipe [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         orow_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         orow_q  <= orow_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      row_d     = row_q;
      addr_d    = addr_q;
      orow_d    = orow_q;
      wcnt_d    = wcnt_q;
      flush     = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      mem_rd_en = (state_q == S_LOAD);
      out_valid = (state_q == S_DRAIN);

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_LOAD;
               ch_d    = '0;
               row_d   = '0;
               addr_d  = '0;
               orow_d  = '0;
               wcnt_d  = '0;
            end
         end
         S_LOAD: begin
            if (row_q == ROW_LAST) begin
               state_d = S_WAIT;
               wcnt_d  = '0;
            end else begin
               row_d  = row_q + RW'(1);
               addr_d = addr_q + AW'(1);
            end
         end
         S_WAIT: begin
            if (wcnt_q == WAIT_LAST) begin
               state_d = S_DRAIN;
               orow_d  = '0;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (orow_q != OROW_LAST) begin
                  orow_d = orow_q + OW'(1);
               end else if (ch_q == CH_LAST) begin
                  state_d = S_DONE;
               end else begin
                  // Channel slices are contiguous in SRAM, so the address just keeps counting.
                  state_d = S_LOAD;
                  ch_d    = ch_q + CW'(1);
                  row_d   = '0;
                  addr_d  = addr_q + AW'(1);
                  orow_d  = '0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ch_d    = '0;
            row_d   = '0;
            addr_d  = '0;
            orow_d  = '0;
            wcnt_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         ch_d    = '0;
         row_d   = '0;
         addr_d  = '0;
         orow_d  = '0;
         wcnt_d  = '0;
         flush   = 1'b1;
      end
   end

   // Slice write strobe trails the read strobe by the SRAM latency; abort drops reads in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) row_pipe[i] <= '0;
      end else if (flush) begin
         we_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) row_pipe[i] <= '0;
      end else begin
         we_pipe[0]  <= (state_q == S_LOAD);
         row_pipe[0] <= row_q;
         for (int i = 1; i < RD_LAT; i++) begin
            we_pipe[i]  <= we_pipe[i-1];
            row_pipe[i] <= row_pipe[i-1];
         end
      end
   end

   assign mem_rd_addr = addr_q;
   assign slice_we    = we_pipe[RD_LAT-1];
   assign slice_row   = row_pipe[RD_LAT-1];
   assign out_row     = orow_q;
   assign out_ch      = ch_q;

endmodule

// File: tb/tb_fds_channel_scheduler.sv
// Scoreboard bench for fds_channel_scheduler: directed layers push expected read, slice-write,
// handshake and done events; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_fds_channel_scheduler;
   localparam int CIN = 2, HIN = 4, HOUT = 3, RD_LAT = 1, DS_LAT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       out_ready = 1'b1;
   logic       busy, done, mem_rd_en, slice_we, out_valid;
   logic [2:0] mem_rd_addr;
   logic [1:0] slice_row;
   logic [1:0] out_row;
   logic [0:0] out_ch;

   fds_channel_scheduler #(
      .CIN(CIN), .HIN(HIN), .HOUT(HOUT), .RD_LAT(RD_LAT), .DS_LAT(DS_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .slice_we(slice_we), .slice_row(slice_row),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_ch(out_ch)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int a;
      int b;
   } ev_t;

   ev_t q_rd[$], q_we[$], q_hs[$], q_done[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk(input int c, input int a, input int b);
      ev_t e;
      e.c = c;
      e.a = a;
      e.b = b;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected events of one full layer started in cycle t0; len = stall cycles on ch0 row 0.
   task automatic push_layer(input int t0, input int len, input bit with_done);
      for (int c = 0; c < CIN; c++) begin
         int s;
         s = c * 10 + ((c > 0) ? len : 0);
         for (int r = 0; r < HIN; r++) begin
            q_rd.push_back(mk(t0 + 1 + s + r, c * HIN + r, 0));
            q_we.push_back(mk(t0 + 2 + s + r, r, 0));
         end
         for (int k = 0; k < HOUT; k++)
            q_hs.push_back(mk(t0 + 8 + s + k + ((c == 0) ? len : 0), c, k));
      end
      if (with_done) q_done.push_back(mk(t0 + 21 + len, 0, 0));
   endtask

   task automatic clear_queues();
      q_rd.delete();
      q_we.delete();
      q_hs.delete();
      q_done.delete();
   endtask

   task automatic chk_empty(input string nm);
      chk({nm, " rd left"}, q_rd.size(), 0);
      chk({nm, " we left"}, q_we.size(), 0);
      chk({nm, " hs left"}, q_hs.size(), 0);
      chk({nm, " done left"}, q_done.size(), 0);
      clear_queues();
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         if (mem_rd_en) begin
            if (q_rd.size() == 0) chk("rd unexpected", 1, 0);
            else begin
               e = q_rd.pop_front();
               chk("rd cycle", cyc, e.c);
               chk("rd addr", int'(mem_rd_addr), e.a);
            end
         end
         if (slice_we) begin
            if (q_we.size() == 0) chk("we unexpected", 1, 0);
            else begin
               e = q_we.pop_front();
               chk("we cycle", cyc, e.c);
               chk("we row", int'(slice_row), e.a);
            end
         end
         if (out_valid && out_ready) begin
            if (q_hs.size() == 0) chk("hs unexpected", 1, 0);
            else begin
               e = q_hs.pop_front();
               chk("hs cycle", cyc, e.c);
               chk("hs ch", int'(out_ch), e.a);
               chk("hs row", int'(out_row), e.b);
            end
         end else if (out_valid && q_hs.size() > 0) begin
            chk("hold ch", int'(out_ch), q_hs[0].a);
            chk("hold row", int'(out_row), q_hs[0].b);
         end
         if (done) begin
            if (q_done.size() == 0) chk("done unexpected", 1, 0);
            else begin
               e = q_done.pop_front();
               chk("done cycle", cyc, e.c);
            end
         end
      end
   end

   task automatic run_layer(input int len, input bit extra_start);
      int t0;
      start = 1'b1;
      t0 = cyc;
      push_layer(t0, len, 1'b1);
      tick();
      start = 1'b0;
      while (cyc - t0 < 26 + len) begin
         int rel;
         rel = cyc - t0;
         start = extra_start && (rel == 3 || rel == 9);
         out_ready = !(rel >= 8 && rel < 8 + len);
         if (rel == 21 + len) chk("busy at done", int'(busy), 1);
         if (rel == 22 + len) chk("busy after done", int'(busy), 0);
         tick();
      end
      start = 1'b0;
      out_ready = 1'b1;
      chk_empty("layer");
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, " busy"}, int'(busy), 0);
      chk({nm, " done"}, int'(done), 0);
      chk({nm, " rd_en"}, int'(mem_rd_en), 0);
      chk({nm, " addr"}, int'(mem_rd_addr), 0);
      chk({nm, " we"}, int'(slice_we), 0);
      chk({nm, " out_valid"}, int'(out_valid), 0);
      chk({nm, " out_row"}, int'(out_row), 0);
      chk({nm, " out_ch"}, int'(out_ch), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst_n = 1'b0;
      #2;
      chk_outputs_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset asserted mid-LOAD.
      start = 1'b1;
      t0 = cyc;
      push_layer(t0, 0, 1'b1);
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("pre-reset rd_en", int'(mem_rd_en), 1);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("async reset");
      clear_queues();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      run_layer(0, 1'b0);
      run_layer(0, 1'b0);
      run_layer(5, 1'b0);
      run_layer(0, 1'b1);

      // Abort mid-LOAD: read of row 3 still seen, its slice write is flushed.
      start = 1'b1;
      t0 = cyc;
      for (int r = 0; r < HIN; r++) q_rd.push_back(mk(t0 + 1 + r, r, 0));
      for (int r = 0; r < HIN - 1; r++) q_we.push_back(mk(t0 + 2 + r, r, 0));
      tick();
      start = 1'b0;
      while (cyc - t0 < 4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort busy", int'(busy), 0);
      chk("abort rd_en", int'(mem_rd_en), 0);
      repeat (12) tick();
      chk_empty("abort");
      run_layer(0, 1'b0);

      // Abort and start together in IDLE.
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort+start busy", int'(busy), 0);
      repeat (3) tick();
      chk("abort+start busy later", int'(busy), 0);
      chk_empty("abort+start");

      // Abort coincident with the final handshake.
      start = 1'b1;
      t0 = cyc;
      push_layer(t0, 0, 1'b0);
      tick();
      start = 1'b0;
      while (cyc - t0 < 20) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("final abort done", int'(done), 0);
      chk("final abort busy", int'(busy), 0);
      repeat (4) tick();
      chk_empty("final abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
